// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, op codes, instruction field positions and controller states
package alu_pkg;
    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int REG_W  = 2;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam int OP_LSB = 6;
    localparam int RD_LSB = 4;
    localparam int RA_LSB = 2;
    localparam int RB_LSB = 0;
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction handshake, direct-load and writeback report bundle
interface alu_ctrl_if import alu_pkg::*; ();
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr;
    logic              ld_en;
    logic [REG_W-1:0]  ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              res_valid;
    logic [REG_W-1:0]  res_addr;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic [7:0]        op_count;
    modport master (
        output instr_valid, instr, ld_en, ld_addr, ld_data,
        input  instr_ready, res_valid, res_addr, res_data, res_zero, op_count
    );
    modport slave (
        input  instr_valid, instr, ld_en, ld_addr, ld_data,
        output instr_ready, res_valid, res_addr, res_data, res_zero, op_count
    );
endinterface

// File: rtl/alu.sv
// alu: combinational 8-bit ALU; ops 2'b10/2'b11 yield zero
module alu import alu_pkg::*; (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] c
);
    always_comb c = op == OP_ADD ? a + b : op == OP_AND ? a & b : '0;
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: four-phase sequencer (accept, read, execute, writeback) around alu over a 4-entry register file
module alu_ctrl import alu_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    alu_ctrl_if.slave  bus
);
    state_t            state, nxt;
    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] opa, opb, c;
    logic [7:0]        ir;
    logic [1:0]        op;
    logic [REG_W-1:0]  rd, ra, rb;
    assign op = ir[OP_LSB +: 2];
    assign rd = ir[RD_LSB +: REG_W];
    assign ra = ir[RA_LSB +: REG_W];
    assign rb = ir[RB_LSB +: REG_W];
    alu u_alu (.a(opa), .b(opb), .op(op), .c(c));
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.instr_valid ? READ : IDLE;
            READ:    nxt = EXEC;
            EXEC:    nxt = WB;
            default: nxt = IDLE;
        endcase
        bus.instr_ready = state == IDLE;
        bus.res_valid   = state == WB;
    end
    // res_* are registered at the end of EXEC so they stay put after the writeback pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            opa          <= '0;
            opb          <= '0;
            ir           <= '0;
            bus.res_addr <= '0;
            bus.res_data <= '0;
            bus.res_zero <= 1'b0;
            bus.op_count <= '0;
        end else begin
            if (state == IDLE && bus.ld_en) rf[bus.ld_addr] <= bus.ld_data;
            if (state == IDLE && bus.instr_valid) ir <= bus.instr;
            if (state == READ) begin
                opa <= rf[ra];
                opb <= rf[rb];
            end
            if (state == EXEC) begin
                bus.res_addr <= rd;
                bus.res_data <= c;
                bus.res_zero <= c == '0;
            end
            if (state == WB) begin
                rf[bus.res_addr] <= bus.res_data;
                bus.op_count     <= bus.op_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed and randomized checks of alu_ctrl against a register-file reference model
module tb_alu_ctrl;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_q[$];
    int rv_q[$];
    logic [7:0] rvd_q[$];
    logic [7:0] m_rf [4];
    int m_cnt = 0;
    always #5 clk = ~clk;
    alu_ctrl_if bus();
    alu_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    // cycle-stamped record of handshakes and writeback pulses
    always @(negedge clk) begin
        cyc++;
        if (bus.instr_valid && bus.instr_ready && !rst) acc_q.push_back(cyc);
        if (bus.res_valid) begin
            rv_q.push_back(cyc);
            rvd_q.push_back(bus.res_data);
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(a) + int'(b);
        if (op == 2'b00) return 8'(s % 256);
        if (op == 2'b01) return a & b;
        return 8'h00;
    endfunction
    task automatic load(input logic [1:0] a, input logic [7:0] d);
        bus.ld_en = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(posedge clk); #1;
        bus.ld_en = 1'b0;
        m_rf[a] = d;
    endtask
    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                         input bit dl, input logic [1:0] la, input logic [7:0] ld,
                         input bit nz, input logic [1:0] na, input logic [7:0] nd);
        logic [7:0] exp;
        int n;
        chk("ready", 32'(bus.instr_ready), 1);
        bus.instr_valid = 1'b1;
        bus.instr = {op, rd, ra, rb};
        bus.ld_en = dl;
        bus.ld_addr = la;
        bus.ld_data = ld;
        if (dl) m_rf[la] = ld;
        exp = alu_ref(op, m_rf[ra], m_rf[rb]);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr = 8'($urandom);
        bus.ld_en = nz;
        bus.ld_addr = na;
        bus.ld_data = nd;
        n = 1;
        while (!bus.res_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 3);
        chk("res_addr", 32'(bus.res_addr), 32'(rd));
        chk("res_data", 32'(bus.res_data), 32'(exp));
        chk("res_zero", 32'(bus.res_zero), 32'(exp == 8'h00));
        m_rf[rd] = exp;
        m_cnt = (m_cnt + 1) % 256;
        @(posedge clk); #1;
        bus.ld_en = 1'b0;
        chk("op_count", 32'(bus.op_count), 32'(m_cnt));
        chk("ready_again", 32'(bus.instr_ready), 1);
        chk("pulse_end", 32'(bus.res_valid), 0);
        chk("hold_data", 32'(bus.res_data), 32'(exp));
    endtask
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
    initial begin
        int n, a0, r0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.ld_en = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(bus.instr_ready), 1);
        chk("rst_valid", 32'(bus.res_valid), 0);
        chk("rst_addr", 32'(bus.res_addr), 0);
        chk("rst_data", 32'(bus.res_data), 0);
        chk("rst_zero", 32'(bus.res_zero), 0);
        chk("rst_count", 32'(bus.op_count), 0);
        @(posedge clk); #1 rst = 1'b0;
        load(2'd0, 8'h05);
        load(2'd1, 8'h03);
        issue(2'b00, 2'd2, 2'd0, 2'd1, 0, 0, 0, 0, 0, 0);
        chk("plan_add", 32'(bus.res_data), 32'h08);
        chk("plan_cnt", 32'(bus.op_count), 1);
        load(2'd0, 8'hFF);
        load(2'd1, 8'h01);
        issue(2'b00, 2'd3, 2'd0, 2'd1, 0, 0, 0, 0, 0, 0);
        chk("plan_wrapadd", 32'(bus.res_data), 0);
        chk("plan_wrapzero", 32'(bus.res_zero), 1);
        load(2'd0, 8'hF0);
        load(2'd1, 8'h3C);
        issue(2'b01, 2'd2, 2'd0, 2'd1, 0, 0, 0, 0, 0, 0);
        chk("plan_and", 32'(bus.res_data), 32'h30);
        issue(2'b10, 2'd1, 2'd0, 2'd1, 0, 0, 0, 0, 0, 0);
        chk("plan_op2", 32'(bus.res_data), 0);
        chk("plan_op2_zero", 32'(bus.res_zero), 1);
        chk("plan_op2_cnt", 32'(bus.op_count), 4);
        load(2'd0, 8'h05);
        load(2'd1, 8'h03);
        a0 = acc_q.size();
        r0 = rv_q.size();
        bus.instr_valid = 1'b1;
        bus.instr = 8'b00_10_00_01;
        @(posedge clk); #1;
        bus.instr = 8'b00_11_10_10;
        n = 0;
        while (acc_q.size() < a0 + 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        bus.instr_valid = 1'b0;
        n = 0;
        while (rv_q.size() < r0 + 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_accepts", 32'(acc_q.size() - a0), 2);
        chk("b2b_results", 32'(rv_q.size() - r0), 2);
        if (acc_q.size() >= a0 + 2 && rv_q.size() >= r0 + 2) begin
            chk("b2b_gap", 32'(acc_q[a0 + 1] - acc_q[a0]), 4);
            chk("b2b_lat", 32'(rv_q[r0] - acc_q[a0]), 3);
            chk("b2b_first", 32'(rvd_q[r0]), 32'h08);
            chk("b2b_second", 32'(rvd_q[r0 + 1]), 32'h10);
        end
        m_rf[2] = 8'h08;
        m_rf[3] = 8'h10;
        m_cnt = (m_cnt + 2) % 256;
        chk("b2b_cnt", 32'(bus.op_count), 32'(m_cnt));
        load(2'd0, 8'h5A);
        issue(2'b00, 2'd3, 2'd0, 2'd1, 0, 0, 0, 1, 2'd0, 8'hAA);
        issue(2'b01, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        chk("ld_ignored", 32'(bus.res_data), 32'h5A);
        load(2'd0, 8'h05);
        load(2'd1, 8'h03);
        r0 = rv_q.size();
        bus.instr_valid = 1'b1;
        bus.instr = 8'b00_10_00_01;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.instr_ready), 1);
        chk("abort_count", 32'(bus.op_count), 0);
        chk("abort_valid", 32'(bus.res_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_wb", 32'(rv_q.size() - r0), 0);
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_cnt = 0;
        issue(2'b00, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 0);
        chk("abort_add", 32'(bus.res_data), 0);
        // enough random instructions to carry op_count through its wrap
        for (int k = 0; k < 270; k++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) load(2'($urandom), 8'($urandom));
            issue(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                  1'($urandom), 2'($urandom), 8'($urandom),
                  1'($urandom), 2'($urandom), 8'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing controller that drives the team's 8-bit combinational ALU. Accepts packed instructions over a valid/ready handshake, reads two operands from a 4-entry register file, executes through the ALU, and writes the result back. Sits between the instruction source (test host or future fetch unit) and the ALU datapath, and is the initiator side of the ALU's a/b/op interface.

## Interface
- DATA_W, 8, operand/result width; fixed to the ALU width.
- NREG, 4, register-file entries; register index is 2 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  controller can accept; high only in IDLE.
- instr  input  8  [7:6] op, [5:4] rd, [3:2] ra, [1:0] rb.
- ld_en  input  1  direct register load strobe.
- ld_addr  input  2  load target register.
- ld_data  input  8  load value.
- res_valid  output  1  one-cycle pulse on writeback.
- res_addr  output  2  destination register of the written result.
- res_data  output  8  written result.
- res_zero  output  1  result == 0, qualified by res_valid.
- op_count  output  8  completed instructions, wraps 0xFF -> 0x00.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. When instr_valid && instr_ready, latch instr and go to READ. Otherwise stay in IDLE.
- READ: register opA=rf[ra] and opB=rf[rb], then go to EXEC.
- EXEC: drive the ALU with a=opA, b=opB, op=op. Register the ALU output into the result register, then go to WB.
- WB: rf[rd] <= result. Pulse res_valid with res_addr=rd, res_data=result, res_zero=(result==8'h00). Increment op_count, then go to IDLE.
- Op encoding is owned by the ALU:
  - 2'b00: ADD, 8-bit modulo with carry discarded.
  - 2'b01: bitwise AND.
  - 2'b10 and 2'b11: result 8'h00 (res_zero=1). This is a legal instruction and still writes back and counts.
- Loads: ld_en is honored only in cycles where instr_ready=1; it is silently ignored in READ, EXEC and WB.
  - A load and an instruction accept in the same IDLE cycle both take effect.
  - The instruction's READ sees the loaded value.
- ra, rb and rd may alias. Operands are captured in READ, so rd==ra is well defined.

## Timing
- Reset values, asserted asynchronously:
  - state=IDLE, all rf entries, opA, opB, result and latched instr = 0.
  - instr_ready=1, res_valid=0, res_addr=0, res_data=0, res_zero=0, op_count=0.
- Latency: handshake in cycle N, res_valid high in cycle N+3, instr_ready high again in cycle N+4.
- Throughput: one instruction per 4 cycles. With instr_valid held high, accepts occur every 4th cycle.
- res_addr, res_data and res_zero hold their last value after the res_valid pulse.
- The instr bus is don't-care when no handshake occurs. The source must hold instr stable while valid && !ready.
- Reset mid-operation (READ/EXEC/WB) aborts: no writeback, no res_valid, op_count cleared.
- op_count wrap: 256th completion returns it to 0x00.

## Structure
- Shared package alu_pkg holds:
  - op codes OP_ADD=2'b00, OP_AND=2'b01.
  - the FSM state enum.
  - instr field bit positions.
  - DATA_W and NREG.
- Sub-module: one instance of the existing `alu` (a, b, op -> c), purely combinational. The controller adds no arithmetic of its own apart from the zero compare and op_count.

## Test plan
- Load r0=0x05, r1=0x03, then issue instr {00,10,00,01}:
  - res_valid exactly 3 cycles after the handshake.
  - res_addr=2, res_data=0x08, res_zero=0, op_count=1.
- Load r0=0xFF, r1=0x01, then issue ADD rd=3: res_data=0x00, res_zero=1.
- Load r0=0xF0, r1=0x3C:
  - AND rd=2 gives 0x30.
  - Then op 2'b10 gives 0x00 with res_zero=1 and op_count incremented.
- Hold instr_valid high with two back-to-back instructions: ADD r2=r0+r1, then ADD r3=r2+r2.
  - Accepts 4 cycles apart.
  - With r0=0x05, r1=0x03, the second result is 0x10.
- Assert ld_en (ld_addr=0, ld_data=0xAA) during EXEC: the load is ignored, and a later AND r0&r0 returns the previous r0.
- Pulse rst during EXEC:
  - No res_valid.
  - instr_ready=1 immediately, op_count=0.
  - A following ADD r0+r1 returns 0x00.
